cache_axi_arbiter: RTL and testbench
====================================

Name: cache_axi_arbiter

Overview:
- Shares the single cache-side port of the AXI interface between three requesters: ICache line refill (read), DCache line refill (read) and DCache writeback (write).
- Sits between the cache block and the AXI interface inside the CPU top.
- Read channel: 2-way round-robin grant, held for the whole burst.
- Write channel: one burst in flight, tracked to final response. Reads to a line being written back are blocked until that writeback completes.

Parameters:
- LINE_OFF_W, 5, byte-offset bits of a cache line; line address = addr[31:LINE_OFF_W].
- LEN_W, 4, burst length field width; beats = len+1.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- ic_req_i  in  1  ICache refill request, held until ic_rlast_o
- ic_addr_i  in  32  ICache refill address
- ic_len_i  in  LEN_W  ICache burst length
- ic_rvalid_o  out  1  beat valid to ICache
- ic_rlast_o  out  1  final beat to ICache
- dc_req_i  in  1  DCache refill request, held until dc_rlast_o
- dc_addr_i  in  32  DCache refill address
- dc_len_i  in  LEN_W  DCache burst length
- dc_rvalid_o  out  1  beat valid to DCache
- dc_rlast_o  out  1  final beat to DCache
- rdata_o  out  32  read data shared by both readers (= axi_rdata_i)
- wb_req_i  in  1  DCache writeback request, held until wb_done_o
- wb_addr_i  in  32  writeback address
- wb_len_i  in  LEN_W  writeback burst length
- wb_sel_i  in  4  byte enables
- wb_data_i  in  32  current beat data
- wb_beat_ack_o  out  1  current beat accepted; advance data
- wb_done_o  out  1  final beat acknowledged
- axi_ce_o  out  1  = axi_ren_o | axi_wen_o
- axi_ren_o  out  1  read burst active
- axi_raddr_o  out  32  latched read address
- axi_rlen_o  out  LEN_W  latched read length
- axi_rready_o  out  1  ready for read data
- axi_rdata_i  in  32  read data
- axi_rvalid_i  in  1  read beat valid
- axi_wen_o  out  1  write burst active
- axi_waddr_o  out  32  latched write address
- axi_wlen_o  out  LEN_W  latched write length
- axi_sel_o  out  4  byte enables
- axi_wdata_o  out  32  write data
- axi_wvalid_o  out  1  write data valid
- axi_wlast_o  out  1  last write beat
- axi_bvalid_i  in  1  per-beat write response

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-high. All outputs and state reset to 0 / IDLE; last_gnt resets to ICache.
- Reset mid-burst: aborts immediately. Requesters and the AXI interface share the reset, so no partial-burst recovery is required.
- Read FSM states: R_IDLE, R_IC, R_DC.
- R_IDLE: an eligible requester is one with req=1 and not hazard-blocked.
  - One eligible: grant it.
  - Both eligible: grant the one that is not last_gnt.
  - On grant: latch addr/len into axi_raddr_o/axi_rlen_o, clear beat_cnt, next state R_IC or R_DC, update last_gnt.
  - First axi_ren_o is the cycle after the request is seen (1-cycle latency).
- R_IC / R_DC:
  - axi_ren_o=1 and axi_rready_o=1.
  - ic_rvalid_o or dc_rvalid_o = axi_rvalid_i, routed to the owner only.
  - beat_cnt increments on each axi_rvalid_i.
  - When axi_rvalid_i and beat_cnt==axi_rlen_o: assert owner's *_rlast_o that cycle and return to R_IDLE.
  - Back-to-back grant is possible the following cycle.
- Hazard: a read is blocked while W_BUSY and read_addr[31:LINE_OFF_W] == axi_waddr_o[31:LINE_OFF_W]. This applies to both readers and prevents a stale refill of a line being evicted.
- Write FSM states: W_IDLE, W_BUSY.
- W_IDLE: wb_req_i latches addr/len/sel, clears wbeat_cnt, moves to W_BUSY.
- W_BUSY:
  - axi_wen_o=1, axi_wvalid_o=1, axi_wdata_o=wb_data_i (combinational pass).
  - axi_wlast_o = (wbeat_cnt==axi_wlen_o).
  - Each axi_bvalid_i: wb_beat_ack_o=1 and wbeat_cnt++.
  - axi_bvalid_i on the last beat: wb_done_o=1, return to W_IDLE.
- Channel independence: read and write FSMs run concurrently. A simultaneous read grant and write start in the same cycle are both legal.
- Requests deasserted without a grant are ignored.
- len=0: single beat; rlast/wlast on the first beat.
- Counters are LEN_W wide; len=15 gives 16 beats with no wrap.

Decomposition:
- Shared package (cache_axi_defs):
  - read/write state encodings
  - LEN_W, LINE_OFF_W defaults
  - requester index constants (REQ_IC=0, REQ_DC=1)
- Sub-module rr_arb2: 2-input round-robin picker with last_gnt flop; outputs a one-hot grant.

Test Plan:
- IC-only refill: ic_req_i=1, addr 0x1FC0_0000, len=7, 8 rvalid beats → axi_ren_o high cycles 1..8; ic_rvalid_o 8×; ic_rlast_o on beat 8; dc_rvalid_o never 1.
- Simultaneous IC+DC with last_gnt=IC → DC granted first (addr 0x0000_1000). IC is granted the cycle after dc_rlast_o, then DC again on the next tie.
- Hazard: writeback to 0x0000_2040 in W_BUSY, DC refill of 0x0000_2058 (same line) → no DC grant until the cycle after wb_done_o. DC refill of 0x0000_2060 is granted immediately.
- Writeback len=3 with bvalid gaps of 0/2/1 cycles → wb_beat_ack_o 4×; axi_wlast_o only during beat 4; wb_done_o once.
- len=0 read and write concurrently → one beat each; rlast and wb_done asserted the same cycle; both FSMs back in IDLE.
- rst asserted mid-burst (beat 3 of 8) → all outputs 0 in the same cycle; after release a new IC request is granted normally.

Source files
------------

// File: rtl/cache_axi_arbiter_pkg.sv
// Shared definitions for the cache-side AXI port arbiter: FSM encodings,
// default geometry and requester indices.
package cache_axi_defs;

  localparam int LEN_W_DEF      = 4;
  localparam int LINE_OFF_W_DEF = 5;

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_IC   = 2'd1;
  localparam logic [1:0] R_DC   = 2'd2;

  localparam logic [0:0] W_IDLE = 1'b0;
  localparam logic [0:0] W_BUSY = 1'b1;

  localparam int REQ_IC = 0;
  localparam int REQ_DC = 1;

endpackage

// File: rtl/cache_axi_arbiter_rr_arb2.sv
// Two-input round-robin picker. On a tie the requester that did not win
// last time is chosen; last_gnt only moves when the grant is consumed.
module rr_arb2
  import cache_axi_defs::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       take,
  output logic [1:0] gnt
);

  logic last_gnt;  // 0: ICache won last, 1: DCache won last

  always_comb begin
    gnt = req;
    if (&req) gnt = last_gnt ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                last_gnt <= 1'b0;
    else if (take && |gnt)  last_gnt <= gnt[REQ_DC];
  end

endmodule

// File: rtl/cache_axi_arbiter.sv
// Shares the cache-side AXI port between ICache refill, DCache refill and
// DCache writeback. Read and write channels run independent FSMs.
module cache_axi_arbiter
  import cache_axi_defs::*;
#(
  parameter int LINE_OFF_W = LINE_OFF_W_DEF,
  parameter int LEN_W      = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ic_req_i,
  input  logic [31:0]      ic_addr_i,
  input  logic [LEN_W-1:0] ic_len_i,
  output logic             ic_rvalid_o,
  output logic             ic_rlast_o,
  input  logic             dc_req_i,
  input  logic [31:0]      dc_addr_i,
  input  logic [LEN_W-1:0] dc_len_i,
  output logic             dc_rvalid_o,
  output logic             dc_rlast_o,
  output logic [31:0]      rdata_o,
  input  logic             wb_req_i,
  input  logic [31:0]      wb_addr_i,
  input  logic [LEN_W-1:0] wb_len_i,
  input  logic [3:0]       wb_sel_i,
  input  logic [31:0]      wb_data_i,
  output logic             wb_beat_ack_o,
  output logic             wb_done_o,
  output logic             axi_ce_o,
  output logic             axi_ren_o,
  output logic [31:0]      axi_raddr_o,
  output logic [LEN_W-1:0] axi_rlen_o,
  output logic             axi_rready_o,
  input  logic [31:0]      axi_rdata_i,
  input  logic             axi_rvalid_i,
  output logic             axi_wen_o,
  output logic [31:0]      axi_waddr_o,
  output logic [LEN_W-1:0] axi_wlen_o,
  output logic [3:0]       axi_sel_o,
  output logic [31:0]      axi_wdata_o,
  output logic             axi_wvalid_o,
  output logic             axi_wlast_o,
  input  logic             axi_bvalid_i
);

  logic [1:0]       r_state;
  logic [0:0]       w_state;
  logic [LEN_W-1:0] beat_cnt;
  logic [LEN_W-1:0] wbeat_cnt;
  logic             r_idle, r_ic, r_dc, w_busy;
  logic             ic_blk, dc_blk, rd_at_last;
  logic [1:0]       elig, gnt;

  assign r_idle = (r_state == R_IDLE);
  assign r_ic   = (r_state == R_IC);
  assign r_dc   = (r_state == R_DC);
  assign w_busy = (w_state == W_BUSY);

  // A refill of the line currently being written back would fetch stale data.
  assign ic_blk = w_busy && (ic_addr_i[31:LINE_OFF_W] == axi_waddr_o[31:LINE_OFF_W]);
  assign dc_blk = w_busy && (dc_addr_i[31:LINE_OFF_W] == axi_waddr_o[31:LINE_OFF_W]);

  always_comb begin
    elig         = '0;
    elig[REQ_IC] = ic_req_i && !ic_blk;
    elig[REQ_DC] = dc_req_i && !dc_blk;
  end

  rr_arb2 u_arb (
    .clk  (clk),
    .rst  (rst),
    .req  (elig),
    .take (r_idle),
    .gnt  (gnt)
  );

  // Read channel
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= R_IDLE;
      beat_cnt    <= '0;
      axi_raddr_o <= '0;
      axi_rlen_o  <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          beat_cnt <= '0;
          if (gnt[REQ_IC]) begin
            r_state     <= R_IC;
            axi_raddr_o <= ic_addr_i;
            axi_rlen_o  <= ic_len_i;
          end else if (gnt[REQ_DC]) begin
            r_state     <= R_DC;
            axi_raddr_o <= dc_addr_i;
            axi_rlen_o  <= dc_len_i;
          end
        end
        R_IC, R_DC: begin
          if (axi_rvalid_i) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (rd_at_last) r_state <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  assign rd_at_last   = (beat_cnt == axi_rlen_o);
  assign axi_ren_o    = r_ic | r_dc;
  assign axi_rready_o = axi_ren_o;
  assign ic_rvalid_o  = r_ic & axi_rvalid_i;
  assign dc_rvalid_o  = r_dc & axi_rvalid_i;
  assign ic_rlast_o   = ic_rvalid_o & rd_at_last;
  assign dc_rlast_o   = dc_rvalid_o & rd_at_last;
  assign rdata_o      = axi_rdata_i;

  // Write channel: one burst, each bvalid acknowledges one beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state     <= W_IDLE;
      wbeat_cnt   <= '0;
      axi_waddr_o <= '0;
      axi_wlen_o  <= '0;
      axi_sel_o   <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (wb_req_i) begin
            w_state     <= W_BUSY;
            wbeat_cnt   <= '0;
            axi_waddr_o <= wb_addr_i;
            axi_wlen_o  <= wb_len_i;
            axi_sel_o   <= wb_sel_i;
          end
        end
        W_BUSY: begin
          if (axi_bvalid_i) begin
            wbeat_cnt <= wbeat_cnt + 1'b1;
            if (axi_wlast_o) w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  assign axi_wen_o     = w_busy;
  assign axi_wvalid_o  = w_busy;
  assign axi_wdata_o   = w_busy ? wb_data_i : '0;
  assign axi_wlast_o   = w_busy && (wbeat_cnt == axi_wlen_o);
  assign wb_beat_ack_o = w_busy & axi_bvalid_i;
  assign wb_done_o     = wb_beat_ack_o & axi_wlast_o;
  assign axi_ce_o      = axi_ren_o | axi_wen_o;

endmodule

// File: tb/tb_cache_axi_arbiter.sv
// Bench for cache_axi_arbiter: transaction-level model checked every cycle,
// plus directed scenarios with hand-computed cycle/count expectations.
module tb_cache_axi_arbiter;

  logic        clk, rst;
  logic        ic_req_i, dc_req_i, wb_req_i;
  logic [31:0] ic_addr_i, dc_addr_i, wb_addr_i, wb_data_i, axi_rdata_i;
  logic [3:0]  ic_len_i, dc_len_i, wb_len_i, wb_sel_i;
  logic        axi_rvalid_i, axi_bvalid_i;
  logic        ic_rvalid_o, ic_rlast_o, dc_rvalid_o, dc_rlast_o;
  logic [31:0] rdata_o, axi_raddr_o, axi_waddr_o, axi_wdata_o;
  logic        wb_beat_ack_o, wb_done_o, axi_ce_o, axi_ren_o, axi_rready_o;
  logic        axi_wen_o, axi_wvalid_o, axi_wlast_o;
  logic [3:0]  axi_rlen_o, axi_wlen_o, axi_sel_o;

  cache_axi_arbiter dut (
    .clk(clk), .rst(rst),
    .ic_req_i(ic_req_i), .ic_addr_i(ic_addr_i), .ic_len_i(ic_len_i),
    .ic_rvalid_o(ic_rvalid_o), .ic_rlast_o(ic_rlast_o),
    .dc_req_i(dc_req_i), .dc_addr_i(dc_addr_i), .dc_len_i(dc_len_i),
    .dc_rvalid_o(dc_rvalid_o), .dc_rlast_o(dc_rlast_o),
    .rdata_o(rdata_o),
    .wb_req_i(wb_req_i), .wb_addr_i(wb_addr_i), .wb_len_i(wb_len_i),
    .wb_sel_i(wb_sel_i), .wb_data_i(wb_data_i),
    .wb_beat_ack_o(wb_beat_ack_o), .wb_done_o(wb_done_o),
    .axi_ce_o(axi_ce_o), .axi_ren_o(axi_ren_o), .axi_raddr_o(axi_raddr_o),
    .axi_rlen_o(axi_rlen_o), .axi_rready_o(axi_rready_o),
    .axi_rdata_i(axi_rdata_i), .axi_rvalid_i(axi_rvalid_i),
    .axi_wen_o(axi_wen_o), .axi_waddr_o(axi_waddr_o), .axi_wlen_o(axi_wlen_o),
    .axi_sel_o(axi_sel_o), .axi_wdata_o(axi_wdata_o), .axi_wvalid_o(axi_wvalid_o),
    .axi_wlast_o(axi_wlast_o), .axi_bvalid_i(axi_bvalid_i)
  );

  int checks = 0, errors = 0, cyc = 0;
  int n_ren = 0, n_ic_rv = 0, n_dc_rv = 0, n_ic_last = 0, n_ack = 0, n_done = 0, n_wlast = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: who owns the read bus and how many beats remain,
  // whether a writeback is open and how many acks it still needs.
  int          m_owner, m_rleft, m_last, m_wleft, pick;
  bit          m_wr, ic_ok, dc_ok;
  logic [31:0] m_raddr, m_waddr;
  logic [3:0]  m_rlen, m_wlen, m_sel;

  always @(negedge clk) begin
    if (rst) begin
      m_owner = -1; m_rleft = 0; m_last = 0; m_wr = 0; m_wleft = 0;
      m_raddr = 0; m_waddr = 0; m_rlen = 0; m_wlen = 0; m_sel = 0;
      chk("rst_ctl", {ic_rvalid_o, ic_rlast_o, dc_rvalid_o, dc_rlast_o, wb_beat_ack_o,
                      wb_done_o, axi_ce_o, axi_ren_o, axi_rready_o, axi_wen_o,
                      axi_wvalid_o, axi_wlast_o}, 0);
      chk("rst_addr", axi_raddr_o | axi_waddr_o | axi_wdata_o, 0);
      chk("rst_len", {axi_rlen_o, axi_wlen_o, axi_sel_o}, 0);
    end else begin
      chk("ren",      axi_ren_o,    m_owner >= 0);
      chk("rready",   axi_rready_o, m_owner >= 0);
      chk("ic_rv",    ic_rvalid_o,  m_owner == 0 && axi_rvalid_i);
      chk("dc_rv",    dc_rvalid_o,  m_owner == 1 && axi_rvalid_i);
      chk("ic_rlast", ic_rlast_o,   m_owner == 0 && axi_rvalid_i && m_rleft == 1);
      chk("dc_rlast", dc_rlast_o,   m_owner == 1 && axi_rvalid_i && m_rleft == 1);
      chk("raddr",    axi_raddr_o,  m_raddr);
      chk("rlen",     axi_rlen_o,   m_rlen);
      chk("rdata",    rdata_o,      axi_rdata_i);
      chk("wen",      axi_wen_o,    m_wr);
      chk("wvalid",   axi_wvalid_o, m_wr);
      chk("waddr",    axi_waddr_o,  m_waddr);
      chk("wlen",     axi_wlen_o,   m_wlen);
      chk("sel",      axi_sel_o,    m_sel);
      chk("wdata",    axi_wdata_o,  m_wr ? wb_data_i : 32'h0);
      chk("wlast",    axi_wlast_o,  m_wr && m_wleft == 1);
      chk("wb_ack",   wb_beat_ack_o, m_wr && axi_bvalid_i);
      chk("wb_done",  wb_done_o,    m_wr && axi_bvalid_i && m_wleft == 1);
      chk("ce",       axi_ce_o,     (m_owner >= 0) || m_wr);
      n_ren += int'(axi_ren_o);       n_ic_rv += int'(ic_rvalid_o);
      n_dc_rv += int'(dc_rvalid_o);   n_ic_last += int'(ic_rlast_o);
      n_ack += int'(wb_beat_ack_o);   n_done += int'(wb_done_o);
      n_wlast += int'(axi_wlast_o);
      // advance model to the state after the coming clock edge
      if (m_owner >= 0) begin
        if (axi_rvalid_i) begin
          m_rleft--;
          if (m_rleft == 0) m_owner = -1;
        end
      end else begin
        ic_ok = ic_req_i && !(m_wr && (ic_addr_i >> 5) == (m_waddr >> 5));
        dc_ok = dc_req_i && !(m_wr && (dc_addr_i >> 5) == (m_waddr >> 5));
        if (ic_ok && dc_ok) pick = (m_last == 0) ? 1 : 0;
        else if (ic_ok)     pick = 0;
        else if (dc_ok)     pick = 1;
        else                pick = -1;
        if (pick >= 0) begin
          m_owner = pick; m_last = pick;
          m_raddr = pick ? dc_addr_i : ic_addr_i;
          m_rlen  = pick ? dc_len_i : ic_len_i;
          m_rleft = int'(m_rlen) + 1;
        end
      end
      if (m_wr) begin
        if (axi_bvalid_i) begin
          m_wleft--;
          if (m_wleft == 0) m_wr = 0;
        end
      end else if (wb_req_i) begin
        m_wr = 1; m_waddr = wb_addr_i; m_wlen = wb_len_i; m_sel = wb_sel_i;
        m_wleft = int'(wb_len_i) + 1;
      end
    end
  end

  // Read slave: returns a beat every cycle a burst is open
  initial forever begin
    @(posedge clk); #2;
    axi_rvalid_i = axi_ren_o;
    axi_rdata_i  = axi_ren_o ? (32'hD000_0000 | cyc) : 32'h0;
  end

  task automatic rd_req(input int who, input logic [31:0] a, input logic [3:0] l,
                        output int gcyc, output int dcyc);
    if (who == 0) begin ic_req_i = 1; ic_addr_i = a; ic_len_i = l; end
    else          begin dc_req_i = 1; dc_addr_i = a; dc_len_i = l; end
    gcyc = -1; dcyc = -1;
    for (int k = 0; k < 100 && dcyc < 0; k++) begin
      @(negedge clk);
      if (gcyc < 0 && axi_ren_o && axi_raddr_o == a) gcyc = cyc;
      if ((who == 0) ? ic_rlast_o : dc_rlast_o) dcyc = cyc;
    end
    chk("rd_completed", dcyc >= 0, 1);
    @(posedge clk); #1;
    if (who == 0) ic_req_i = 0; else dc_req_i = 0;
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [3:0] l,
                          input int g0, input int g1, input int g2, input int g3,
                          output int dcyc);
    int gaps[4];
    gaps = '{g0, g1, g2, g3};
    wb_req_i = 1; wb_addr_i = a; wb_len_i = l; wb_sel_i = a[7:4];
    wb_data_i = a ^ 32'hA5A5_0000;
    dcyc = -1;
    @(posedge clk); #1;
    for (int b = 0; b <= int'(l); b++) begin
      for (int g = 0; g < gaps[(b > 3) ? 3 : b]; g++) begin
        axi_bvalid_i = 0; @(posedge clk); #1;
      end
      axi_bvalid_i = 1;
      @(negedge clk);
      if (wb_done_o) dcyc = cyc;
      @(posedge clk); #1;
      axi_bvalid_i = 0; wb_data_i = wb_data_i + 1;
    end
    wb_req_i = 0;
  endtask

  int c0, g, d, wd, gi1, di1, gi2, di2, gd1, dd1, gd2, dd2;
  int b_ren, b_icrv, b_dcrv, b_iclast, b_ack, b_done, b_wlast;

  task automatic snap();
    b_ren = n_ren; b_icrv = n_ic_rv; b_dcrv = n_dc_rv; b_iclast = n_ic_last;
    b_ack = n_ack; b_done = n_done; b_wlast = n_wlast;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; ic_req_i = 0; dc_req_i = 0; wb_req_i = 0;
    ic_addr_i = 0; dc_addr_i = 0; wb_addr_i = 0; wb_data_i = 0;
    ic_len_i = 0; dc_len_i = 0; wb_len_i = 0; wb_sel_i = 0;
    axi_rvalid_i = 0; axi_rdata_i = 0; axi_bvalid_i = 0;
    @(negedge clk);
    chk("reset_ren_wen", {axi_ren_o, axi_wen_o, axi_ce_o}, 0);
    @(posedge clk); #1; rst = 0;
    @(posedge clk); #1;

    // IC-only refill, 8 beats
    snap(); c0 = cyc;
    rd_req(0, 32'h1FC0_0000, 4'd7, g, d);
    chk("ic_grant_cycle", g, c0 + 1);
    chk("ic_last_cycle",  d, c0 + 8);
    chk("ic_ren_cycles",  n_ren - b_ren, 8);
    chk("ic_beats",       n_ic_rv - b_icrv, 8);
    chk("ic_rlast_count", n_ic_last - b_iclast, 1);
    chk("ic_no_dc_beats", n_dc_rv - b_dcrv, 0);

    // Ties with last winner = IC: DC, IC, DC, IC
    c0 = cyc;
    fork
      begin rd_req(0, 32'h0000_0100, 4'd1, gi1, di1); rd_req(0, 32'h0000_0140, 4'd1, gi2, di2); end
      begin rd_req(1, 32'h0000_1000, 4'd1, gd1, dd1); rd_req(1, 32'h0000_1040, 4'd1, gd2, dd2); end
    join
    chk("tie_dc1_grant", gd1, c0 + 1);
    chk("tie_dc1_last",  dd1, c0 + 2);
    chk("tie_ic1_grant", gi1, c0 + 4);
    chk("tie_dc2_grant", gd2, c0 + 7);
    chk("tie_ic2_grant", gi2, c0 + 10);

    // Hazard: same-line DC refill waits for writeback; gaps 0/2/1 between beats
    snap(); c0 = cyc;
    fork
      wb_write(32'h0000_2040, 4'd3, 0, 0, 2, 1, wd);
      begin @(posedge clk); #1; rd_req(1, 32'h0000_2058, 4'd0, g, d); end
    join
    chk("wb_done_cycle",  wd, c0 + 7);
    chk("haz_grant",      g, wd + 2);
    chk("wb_ack_count",   n_ack - b_ack, 4);
    chk("wb_done_count",  n_done - b_done, 1);
    chk("wb_wlast_count", n_wlast - b_wlast, 2);

    // Different line is not blocked
    c0 = cyc;
    fork
      wb_write(32'h0000_2040, 4'd1, 3, 3, 0, 0, wd);
      begin @(posedge clk); #1; rd_req(1, 32'h0000_2060, 4'd1, g, d); end
    join
    chk("nohaz_grant", g, c0 + 2);
    chk("nohaz_wdone", wd, c0 + 8);

    // len=0 read and write together
    c0 = cyc;
    fork
      rd_req(0, 32'h0000_3000, 4'd0, g, d);
      wb_write(32'h0000_4000, 4'd0, 0, 0, 0, 0, wd);
    join
    chk("len0_rlast", d, c0 + 1);
    chk("len0_wdone", wd, c0 + 1);
    @(negedge clk);
    chk("len0_idle", {axi_ren_o, axi_wen_o}, 0);

    // Reset during beat 3 of 8
    @(posedge clk); #1;
    ic_req_i = 1; ic_addr_i = 32'h1FC0_0100; ic_len_i = 4'd7;
    repeat (3) begin @(posedge clk); #1; end
    #2; rst = 1; #1;
    chk("rst_mid_ctl", {axi_ren_o, axi_rready_o, axi_ce_o, ic_rvalid_o, ic_rlast_o, axi_wen_o}, 0);
    chk("rst_mid_raddr", axi_raddr_o, 0);
    ic_req_i = 0;
    repeat (2) @(posedge clk);
    #1; rst = 0;
    @(posedge clk); #1;
    c0 = cyc;
    rd_req(0, 32'h0000_5000, 4'd1, g, d);
    chk("post_rst_grant", g, c0 + 1);
    chk("post_rst_last",  d, c0 + 2);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
